enemy_anim_ctrl: RTL and testbench

Parametrised walk-animation sequencer for one enemy sprite.
- Produces the sprite frame index (step count), facing direction and moving flag that the sprite ROM address logic consumes.
- Advances only on frame-clock edges, only while the enemy is moving, with a programmable frame divider and a configurable number of animation frames.
- One instance per enemy, between the enemy motion logic and the colour mapper.

---
 rtl/enemy_anim_ctrl.sv | 163 ++++++++++++++++
 tb/tb_enemy_anim_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/enemy_anim_ctrl.sv
// Walk-animation sequencer for one enemy sprite: step index, facing and moving flag.
// Define ENEMY_ANIM_PINGPONG_EN for a 0..N-1..0 ping-pong step sequence instead of wrap-around.
module enemy_anim_ctrl #(
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned FRAME_W    = 2,
    parameter int unsigned DIV        = 1,
    parameter int unsigned POS_W      = 9
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               Enable,
    input  logic [POS_W-1:0]   Obj_X_Motion,
    input  logic [POS_W-1:0]   Obj_Y_Motion,
    output logic [FRAME_W-1:0] Obj_Step_Count,
    output logic [1:0]         Obj_Dir,
    output logic               Obj_Moving
);

    localparam int unsigned DIV_W = 8;
    localparam logic [FRAME_W-1:0] STEP_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] STEP_ONE  = FRAME_W'(1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DIV - 1);

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t             state_q;
    logic               frame_clk_q;
    logic [DIV_W-1:0]   div_q;
    logic [FRAME_W-1:0] step_q;
    logic [1:0]         dir_q;
    logic               moving_q;

    logic               tick_c;
    logic               moving_c;
    logic [1:0]         dir_c;
    logic [FRAME_W-1:0] step_adv_c;

    // One tick per frame_clk rising edge, however long it stays high.
    assign tick_c   = frame_clk & ~frame_clk_q;
    assign moving_c = Enable & ((Obj_X_Motion != '0) | (Obj_Y_Motion != '0));

    // Horizontal motion wins ties with vertical.
    always_comb begin
        dir_c = DIR_DOWN;
        if (Obj_X_Motion != '0) begin
            dir_c = Obj_X_Motion[POS_W-1] ? DIR_LEFT : DIR_RIGHT;
        end else begin
            dir_c = Obj_Y_Motion[POS_W-1] ? DIR_UP : DIR_DOWN;
        end
    end

`ifdef ENEMY_ANIM_PINGPONG_EN
    logic up_q;
    logic up_adv_c;

    // Reverse at either end without repeating the end frame.
    always_comb begin
        step_adv_c = step_q;
        up_adv_c   = up_q;
        if (up_q) begin
            if (step_q == STEP_LAST) begin
                step_adv_c = step_q - STEP_ONE;
                up_adv_c   = 1'b0;
            end else begin
                step_adv_c = step_q + STEP_ONE;
            end
        end else begin
            if (step_q == '0) begin
                step_adv_c = STEP_ONE;
                up_adv_c   = 1'b1;
            end else begin
                step_adv_c = step_q - STEP_ONE;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            up_q <= 1'b1;
        end else if (tick_c) begin
            if (!moving_c || state_q == IDLE) begin
                up_q <= 1'b1;
            end else if (div_q == DIV_LAST) begin
                up_q <= up_adv_c;
            end
        end
    end
`else
    always_comb begin
        step_adv_c = step_q + STEP_ONE;
        if (step_q == STEP_LAST) begin
            step_adv_c = '0;
        end
    end
`endif

    // Walk FSM; every update is gated by the frame tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            frame_clk_q <= 1'b0;
            div_q       <= '0;
            step_q      <= '0;
            dir_q       <= DIR_DOWN;
            moving_q    <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            if (tick_c) begin
                if (moving_c) begin
                    dir_q <= dir_c;
                end
                case (state_q)
                    IDLE: begin
                        div_q <= '0;
                        if (moving_c) begin
                            state_q  <= WALK;
                            step_q   <= STEP_ONE;
                            moving_q <= 1'b1;
                        end else begin
                            step_q   <= '0;
                            moving_q <= 1'b0;
                        end
                    end
                    WALK: begin
                        if (moving_c) begin
                            if (div_q == DIV_LAST) begin
                                div_q  <= '0;
                                step_q <= step_adv_c;
                            end else begin
                                div_q <= div_q + DIV_W'(1);
                            end
                        end else begin
                            state_q  <= IDLE;
                            step_q   <= '0;
                            div_q    <= '0;
                            moving_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        step_q   <= '0;
                        div_q    <= '0;
                        moving_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Obj_Step_Count = step_q;
    assign Obj_Dir        = dir_q;
    assign Obj_Moving     = moving_q;

endmodule

// File: tb/tb_enemy_anim_ctrl.sv
// Scoreboard bench for enemy_anim_ctrl: one DIV=1 and one DIV=3 instance share stimulus.
module tb_enemy_anim_ctrl;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       Enable;
    logic [8:0] Obj_X_Motion;
    logic [8:0] Obj_Y_Motion;
    logic [1:0] u1_step, u3_step;
    logic [1:0] u1_dir, u3_dir;
    logic       u1_mv, u3_mv;

    enemy_anim_ctrl #(.NUM_FRAMES(4), .FRAME_W(2), .DIV(1), .POS_W(9)) u_div1 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Enable(Enable),
        .Obj_X_Motion(Obj_X_Motion), .Obj_Y_Motion(Obj_Y_Motion),
        .Obj_Step_Count(u1_step), .Obj_Dir(u1_dir), .Obj_Moving(u1_mv)
    );

    enemy_anim_ctrl #(.NUM_FRAMES(4), .FRAME_W(2), .DIV(3), .POS_W(9)) u_div3 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Enable(Enable),
        .Obj_X_Motion(Obj_X_Motion), .Obj_Y_Motion(Obj_Y_Motion),
        .Obj_Step_Count(u3_step), .Obj_Dir(u3_dir), .Obj_Moving(u3_mv)
    );

    typedef struct {
        bit     sel3;
        int     step;
        int     dir;
        int     mv;
        longint due;
        int     tag;
    } exp_t;

    exp_t   q[$];
    exp_t   ent;
    longint cycle_cnt = 0;
    int     checks    = 0;
    int     failures  = 0;
    int     tag_cnt   = 0;

`ifdef ENEMY_ANIM_PINGPONG_EN
    int seq6[6]  = '{1, 2, 3, 2, 1, 0};
    int seq10[10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    int step_t4  = 1;
`else
    int seq6[6]  = '{1, 2, 3, 0, 1, 2};
    int seq10[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    int step_t4  = 3;
`endif
    int seq_div3[7] = '{1, 1, 1, 2, 2, 2, 3};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

    // Monitor: pop every expectation that has come due and compare.
    always @(negedge Clk) begin
        while (q.size() > 0 && q[0].due <= cycle_cnt) begin
            int as, ad, am;
            ent = q.pop_front();
            as = ent.sel3 ? int'(u3_step) : int'(u1_step);
            ad = ent.sel3 ? int'(u3_dir)  : int'(u1_dir);
            am = ent.sel3 ? int'(u3_mv)   : int'(u1_mv);
            checks++;
            if (as != ent.step || ad != ent.dir || am != ent.mv) begin
                failures++;
                $display("FAIL chk%0d div%0d: got step=%0d dir=%0d moving=%0d, want step=%0d dir=%0d moving=%0d",
                         ent.tag, ent.sel3 ? 3 : 1, as, ad, am, ent.step, ent.dir, ent.mv);
            end
        end
    end

    task automatic expect_out(input bit sel3, input int step, input int dir, input int mv);
        exp_t e;
        e.sel3 = sel3;
        e.step = step;
        e.dir  = dir;
        e.mv   = mv;
        e.due  = cycle_cnt;
        e.tag  = tag_cnt;
        tag_cnt++;
        q.push_back(e);
    endtask

    task automatic pulse(input int hold);
        @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (hold) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge Clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations still pending, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
    endtask

    initial begin
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        Enable       = 1'b0;
        Obj_X_Motion = '0;
        Obj_Y_Motion = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk);
        expect_out(1'b0, 0, 0, 0);
        expect_out(1'b1, 0, 0, 0);
        drain();

        // Walk right, one step per tick
        Enable       = 1'b1;
        Obj_X_Motion = 9'd1;
        for (int i = 0; i < 6; i++) begin
            pulse(2);
            expect_out(1'b0, seq6[i], 3, 1);
        end
        drain();

        // Stop: back to idle, direction retained; a second idle tick is a no-op
        pulse(2);
        expect_out(1'b0, step_t4, 3, 1);
        Obj_X_Motion = '0;
        pulse(2);
        expect_out(1'b0, 0, 3, 0);
        pulse(2);
        expect_out(1'b0, 0, 3, 0);
        drain();

        // Long frame_clk high gives a single advance; horizontal wins ties
        Obj_X_Motion = 9'd1;
        pulse(50);
        expect_out(1'b0, 1, 3, 1);
        Obj_X_Motion = -9'sd2;
        Obj_Y_Motion = 9'sd3;
        pulse(2);
        expect_out(1'b0, 2, 2, 1);
        drain();

        // Asynchronous reset mid-walk, observed before the next clock edge
        @(posedge Clk);
        #1 Reset = 1'b1;
        expect_out(1'b0, 0, 0, 0);
        expect_out(1'b1, 0, 0, 0);
        drain();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        repeat (4) @(posedge Clk);
        expect_out(1'b0, 0, 0, 0);
        expect_out(1'b1, 0, 0, 0);
        drain();

        // Divider of 3, walking up
        Obj_X_Motion = '0;
        Obj_Y_Motion = -9'sd1;
        for (int i = 0; i < 7; i++) begin
            pulse(2);
            expect_out(1'b1, seq_div3[i], 1, 1);
        end
        drain();

        // Long step sequence, then Enable=0 forces idle, restart counts up
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pulse(2);
            expect_out(1'b0, seq10[i], 1, 1);
        end
        drain();
        Enable = 1'b0;
        pulse(2);
        expect_out(1'b0, 0, 1, 0);
        expect_out(1'b1, 0, 1, 0);
        pulse(2);
        expect_out(1'b0, 0, 1, 0);
        Enable = 1'b1;
        pulse(2);
        expect_out(1'b0, 1, 1, 1);
        pulse(2);
        expect_out(1'b0, 2, 1, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
